// File: rtl/seq_eq_cmp.sv
// Bit-serial W-bit equality comparator built around a 1-bit equality cell.
// Optional macro SEQ_EQ_EARLY_EXIT_EN: finish as soon as one bit pair differs.

module eq1 (
    input  logic a,
    input  logic b,
    output logic eq
);
    assign eq = ~(a ^ b);
endmodule

// state | meaning
// IDLE  | waiting for start, operands not yet captured
// SHIFT | one bit pair compared per clock, LSB first
// DONE  | one-cycle done pulse, eq carries the new result
module seq_eq_cmp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         eq
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          bit_eq;
    logic          last_bit;
    logic          exit_now;

    eq1 u_eq1 (
        .a  (sa[0]),
        .b  (sb[0]),
        .eq (bit_eq)
    );

    assign last_bit = (cnt == CW'(1));

`ifdef SEQ_EQ_EARLY_EXIT_EN
    // A single mismatch settles the result, so later bits are skipped.
    assign exit_now = last_bit | ~bit_eq;
`else
    assign exit_now = last_bit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            acc   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= CW'(W);
                        acc   <= 1'b1;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc <= acc & bit_eq;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt - CW'(1);
                    if (exit_now) begin
                        eq    <= acc & bit_eq;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_eq_cmp.sv
// Self-checking bench for seq_eq_cmp: W=8 and W=1 instances, directed plus random compares.
// Honours SEQ_EQ_EARLY_EXIT_EN in its reference latency model.

module tb_seq_eq_cmp;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         eq;

    logic         start1 = 1'b0;
    logic         a1 = 1'b0;
    logic         b1 = 1'b0;
    logic         busy1;
    logic         done1;
    logic         eq1_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_eq_cmp #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq)
    );

    seq_eq_cmp #(.W(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .eq    (eq1_out)
    );

    // Reference: result is plain word equality; latency is W, or with early
    // exit the position (1-based) of the lowest differing bit.
    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = W;
`ifdef SEQ_EQ_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (x[i] !== y[i]) n = i + 1;
`endif
        return n;
    endfunction

    task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output logic eq_out, output int busy_n,
                          output int done_n, output logic eq_glitch);
        logic prev_eq;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = -1; busy_n = 0; done_n = 0; eq_glitch = 1'b0;
        eq_out = eq; prev_eq = eq;
        if (busy) busy_n++;
        for (int k = 1; k <= W + 6; k++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) lat = k;
                eq_out = eq;
            end else if (eq !== prev_eq) begin
                eq_glitch = 1'b1;
            end
            prev_eq = eq;
        end
    endtask

    task automatic check_cmp(input string name, input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat, busy_n, done_n, el;
        logic eqv, glitch, ee;
        do_cmp(av, bv, lat, eqv, busy_n, done_n, glitch);
        el = exp_lat(av, bv);
        ee = (av == bv);
        total++;
        if (lat !== el) $display("FAIL %s latency a=%h b=%h got %0d want %0d", name, av, bv, lat, el);
        else passed++;
        total++;
        if (eqv !== ee) $display("FAIL %s eq a=%h b=%h got %b want %b", name, av, bv, eqv, ee);
        else passed++;
        total++;
        if (busy_n !== el + 1) $display("FAIL %s busy_cycles a=%h b=%h got %0d want %0d", name, av, bv, busy_n, el + 1);
        else passed++;
        total++;
        if (done_n !== 1 || glitch !== 1'b0)
            $display("FAIL %s done_pulse/eq_hold got done_n=%0d glitch=%b want 1/0", name, done_n, glitch);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, eq} !== 3'b000) $display("FAIL reset_w8 got busy,done,eq=%b want 000", {busy, done, eq});
        else passed++;
        total++;
        if ({busy1, done1, eq1_out} !== 3'b000) $display("FAIL reset_w1 got busy,done,eq=%b want 000", {busy1, done1, eq1_out});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, eq} !== 3'b000) $display("FAIL idle_after_reset got busy,done,eq=%b want 000", {busy, done, eq});
        else passed++;
    endtask

    task automatic test_directed;
        check_cmp("equal_a5", 8'hA5, 8'hA5);
        check_cmp("bit0_mismatch", 8'hA5, 8'hA4);
        check_cmp("msb_mismatch", 8'h80, 8'h00);
        check_cmp("zero_equal", 8'h00, 8'h00);
    endtask

    task automatic test_random;
        logic [W-1:0] av, bv;
        for (int n = 0; n < 16; n++) begin
            av = W'($urandom);
            case ($urandom_range(0, 2))
                0: bv = av;
                1: bv = av ^ (W'(1) << $urandom_range(0, W - 1));
                default: bv = W'($urandom);
            endcase
            check_cmp("random", av, bv);
        end
    endtask

    task automatic test_back_to_back;
        int done_n, last_done, bad_gap, bad_eq, toggles;
        logic prev_eq;
        done_n = 0; last_done = -1; bad_gap = 0; bad_eq = 0; toggles = 0;
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        @(posedge clk); #1;
        prev_eq = eq;
        for (int k = 1; k <= 3 * (W + 2); k++) begin
            if (busy && !done) begin
                a = 8'hFF; b = 8'h00;
            end else begin
                a = 8'h3C; b = 8'h3C;
            end
            @(posedge clk); #1;
            if (done) begin
                done_n++;
                if (eq !== 1'b1) bad_eq++;
                if (last_done >= 0 && k - last_done != W + 2) bad_gap++;
                last_done = k;
            end else if (eq !== prev_eq) begin
                toggles++;
            end
            prev_eq = eq;
        end
        start = 1'b0;
        a = 8'h3C; b = 8'h3C;
        repeat (W + 4) @(posedge clk);
        #1;
        total++;
        if (done_n !== 3) $display("FAIL b2b_done_count got %0d want 3", done_n);
        else passed++;
        total++;
        if (bad_gap !== 0) $display("FAIL b2b_done_spacing got %0d bad gaps want 0", bad_gap);
        else passed++;
        total++;
        if (bad_eq !== 0) $display("FAIL b2b_eq got %0d results not 1 want 0", bad_eq);
        else passed++;
        total++;
        if (toggles !== 0) $display("FAIL b2b_eq_hold got %0d toggles want 0", toggles);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_reset_midop;
        int done_seen;
        check_cmp("pre_reset_equal", 8'h5A, 8'h5A);
        @(negedge clk);
        a = 8'h5A; b = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, eq} !== 3'b000) $display("FAIL midop_reset_async got busy,done,eq=%b want 000", {busy, done, eq});
        else passed++;
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        total++;
        if (done_seen !== 0) $display("FAIL midop_no_done got %0d active cycles want 0", done_seen);
        else passed++;
        check_cmp("post_reset_equal", 8'h5A, 8'h5A);
    endtask

    task automatic do_cmp1(input string name, input logic av, input logic bv);
        int lat;
        logic eqv;
        @(negedge clk);
        a1 = av; b1 = bv; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = -1; eqv = eq1_out;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (done1 && lat < 0) begin
                lat = k;
                eqv = eq1_out;
            end
        end
        total++;
        if (lat !== 1) $display("FAIL %s latency got %0d want 1", name, lat);
        else passed++;
        total++;
        if (eqv !== (av == bv)) $display("FAIL %s eq got %b want %b", name, eqv, (av == bv));
        else passed++;
    endtask

    task automatic test_w1;
        do_cmp1("w1_equal", 1'b1, 1'b1);
        do_cmp1("w1_diff", 1'b1, 1'b0);
        do_cmp1("w1_zero", 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_midop;
        test_w1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
